// File: rtl/sliding_window_if.sv
// sliding_window_if: sample-in / pair-out bus of the sliding window
interface sliding_window_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_DEPTH = 16
);
  logic                            i_data_valid;
  logic [DATA_WIDTH-1:0]           i_data;
  logic                            i_flush;
  logic [DATA_WIDTH-1:0]           o_incoming_data;
  logic [DATA_WIDTH-1:0]           o_outgoing_data;
  logic                            o_data_valid;
  logic                            o_window_full;
  logic [$clog2(WINDOW_DEPTH):0]   o_fill_count;
  modport master (
    output i_data_valid, i_data, i_flush,
    input  o_incoming_data, o_outgoing_data, o_data_valid, o_window_full, o_fill_count
  );
  modport slave (
    input  i_data_valid, i_data, i_flush,
    output o_incoming_data, o_outgoing_data, o_data_valid, o_window_full, o_fill_count
  );
endinterface

// File: rtl/sliding_window.sv
// sliding_window: circular-buffer window emitting (incoming, evicted) sample pairs
module sliding_window #(
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_DEPTH = 16
) (
  input logic             i_clk,
  input logic             i_reset_n,
  sliding_window_if.slave bus
);
  localparam int PW = $clog2(WINDOW_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [WINDOW_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  accept;
  assign accept    = bus.i_data_valid & ~bus.i_flush;
  assign count_nxt = (state == FULL) ? count : count + 1'b1;
  assign bus.o_window_full = (state == FULL);
  assign bus.o_fill_count  = count;
  // sample storage; contents are only meaningful up to the fill count, so no reset
  always_ff @(posedge i_clk)
    if (accept) mem[wr_ptr] <= bus.i_data;
  // window FSM, pointer/count and registered output pair (evicted value read before write)
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state               <= EMPTY;
      wr_ptr              <= '0;
      count               <= '0;
      bus.o_data_valid    <= 1'b0;
      bus.o_incoming_data <= '0;
      bus.o_outgoing_data <= '0;
    end else if (bus.i_flush) begin
      state            <= EMPTY;
      wr_ptr           <= '0;
      count            <= '0;
      bus.o_data_valid <= 1'b0;
    end else if (accept) begin
      state               <= (count_nxt == CW'(WINDOW_DEPTH)) ? FULL : FILLING;
      wr_ptr              <= wr_ptr + 1'b1;
      count               <= count_nxt;
      bus.o_data_valid    <= 1'b1;
      bus.o_incoming_data <= bus.i_data;
      bus.o_outgoing_data <= (state == FULL) ? mem[wr_ptr] : '0;
    end else begin
      bus.o_data_valid <= 1'b0;
    end
endmodule
